// File: rtl/luna_pkg.sv
// Shared Luna datapath constants: width and ALU opcode encodings.
package luna_pkg;

   localparam int unsigned WIDTH = 16;

   localparam logic [1:0] OP_AND = 2'h0;
   localparam logic [1:0] OP_OR  = 2'h1;
   localparam logic [1:0] OP_ADD = 2'h2;
   localparam logic [1:0] OP_SUB = 2'h3;

endpackage

// File: rtl/luna_alu_if.sv
// Operand/control bus into the Luna ALU and its registered result/flags.
interface luna_alu_if #(
   parameter int unsigned WIDTH = luna_pkg::WIDTH
);
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             zero_x;
   logic             zero_y;
   logic             negate_output;
   logic [1:0]       opcode;
   logic [WIDTH-1:0] output_result;
   logic             is_zero;
   logic             is_negative;

   // Master: the decoder side driving operands and consuming results.
   modport master (
      output x, y, zero_x, zero_y, negate_output, opcode,
      input  output_result, is_zero, is_negative
   );

   // Slave: the ALU itself.
   modport slave (
      input  x, y, zero_x, zero_y, negate_output, opcode,
      output output_result, is_zero, is_negative
   );
endinterface

// File: rtl/luna_alu_comb.sv
// Combinational ALU: operand zeroing, opcode decode, optional inversion and flags.
module luna_alu_comb
   import luna_pkg::*;
#(
   parameter int unsigned WIDTH = luna_pkg::WIDTH
) (
   input  logic [WIDTH-1:0] i_x,
   input  logic [WIDTH-1:0] i_y,
   input  logic             i_zero_x,
   input  logic             i_zero_y,
   input  logic             i_negate,
   input  logic [1:0]       i_opcode,
   output logic [WIDTH-1:0] o_result,
   output logic             o_is_zero,
   output logic             o_is_negative
);

   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;
   logic [WIDTH-1:0] w_op;

   assign w_a = i_zero_x ? '0 : i_x;
   assign w_b = i_zero_y ? '0 : i_y;

   // Opcode decode; add/sub wrap and drop carry.
   always_comb begin
      w_op = '0;
      unique case (i_opcode)
         OP_AND:  w_op = w_a & w_b;
         OP_OR:   w_op = w_a | w_b;
         OP_ADD:  w_op = w_a + w_b;
         OP_SUB:  w_op = w_a - w_b;
         default: w_op = '0;
      endcase
   end

   // Bitwise invert (not two's-complement negate) and derive flags from final value.
   always_comb begin
      o_result      = i_negate ? ~w_op : w_op;
      o_is_zero     = (o_result == '0);
      o_is_negative = o_result[WIDTH-1];
   end

endmodule

// File: rtl/luna_alu_core.sv
// Registered Luna ALU: one-cycle latency, result and flags captured together.
module luna_alu_core
   import luna_pkg::*;
#(
   parameter int unsigned WIDTH = luna_pkg::WIDTH
) (
   input logic      clk,
   input logic      rst,
   luna_alu_if.slave alu
);

   logic [WIDTH-1:0] w_result;
   logic             w_is_zero;
   logic             w_is_negative;

   logic [WIDTH-1:0] r_result;
   logic             r_is_zero;
   logic             r_is_negative;

   luna_alu_comb #(
      .WIDTH (WIDTH)
   ) u_comb (
      .i_x           (alu.x),
      .i_y           (alu.y),
      .i_zero_x      (alu.zero_x),
      .i_zero_y      (alu.zero_y),
      .i_negate      (alu.negate_output),
      .i_opcode      (alu.opcode),
      .o_result      (w_result),
      .o_is_zero     (w_is_zero),
      .o_is_negative (w_is_negative)
   );

   // Output register stage; reset value reflects a zero result (is_zero = 1).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_result      <= '0;
         r_is_zero     <= 1'b1;
         r_is_negative <= 1'b0;
      end else begin
         r_result      <= w_result;
         r_is_zero     <= w_is_zero;
         r_is_negative <= w_is_negative;
      end
   end

   assign alu.output_result = r_result;
   assign alu.is_zero       = r_is_zero;
   assign alu.is_negative   = r_is_negative;

endmodule

// File: tb/tb_luna_alu_core.sv
// Directed self-checking bench for luna_alu_core.
module tb_luna_alu_core;
   import luna_pkg::*;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fails;

   luna_alu_if #(.WIDTH(16)) alu_bus ();

   luna_alu_core #(
      .WIDTH (16)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .alu (alu_bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [15:0] res, input logic zf,
                            input logic nf);
      check({tag, ".result"}, alu_bus.output_result, res);
      check({tag, ".is_zero"}, {15'd0, alu_bus.is_zero}, {15'd0, zf});
      check({tag, ".is_neg"}, {15'd0, alu_bus.is_negative}, {15'd0, nf});
   endtask

   // Drive inputs, let one rising edge capture them, sample 1ns later.
   task automatic step(input string tag, input logic [1:0] op, input logic [15:0] x,
                       input logic [15:0] y, input logic zx, input logic zy, input logic neg,
                       input logic [15:0] res, input logic zf, input logic nf);
      alu_bus.opcode        = op;
      alu_bus.x             = x;
      alu_bus.y             = y;
      alu_bus.zero_x        = zx;
      alu_bus.zero_y        = zy;
      alu_bus.negate_output = neg;
      @(posedge clk);
      #1;
      check_out(tag, res, zf, nf);
   endtask

   initial begin
      n_tests = 0;
      n_fails = 0;
      rst                   = 1'b1;
      alu_bus.x             = 16'h0002;
      alu_bus.y             = 16'h0005;
      alu_bus.zero_x        = 1'b0;
      alu_bus.zero_y        = 1'b0;
      alu_bus.negate_output = 1'b0;
      alu_bus.opcode        = OP_ADD;

      // Reset held 40ns; edges occur during it and must not load.
      #22;
      check_out("rst_hold", 16'h0000, 1'b1, 1'b0);
      #18;
      rst = 1'b0;
      #1;
      check_out("rst_release", 16'h0000, 1'b1, 1'b0);

      step("add_2_5",     OP_ADD, 16'h0002, 16'h0005, 1'b0, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);
      step("add_10_5",    OP_ADD, 16'h000A, 16'h0005, 1'b0, 1'b0, 1'b0, 16'h000F, 1'b0, 1'b0);
      step("add_zx",      OP_ADD, 16'h000A, 16'h0005, 1'b1, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0);
      step("add_zx_y0",   OP_ADD, 16'h000A, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      step("add_zx_neg",  OP_ADD, 16'h000A, 16'h0000, 1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1);
      step("add_zxzy_ng", OP_ADD, 16'h1234, 16'h5678, 1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b1);
      step("sub_2_5",     OP_SUB, 16'h0002, 16'h0005, 1'b0, 1'b0, 1'b0, 16'hFFFD, 1'b0, 1'b1);
      step("add_wrap",    OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      step("and",         OP_AND, 16'hF0F0, 16'h0FF0, 1'b0, 1'b0, 1'b0, 16'h00F0, 1'b0, 1'b0);
      step("or_neg",      OP_OR,  16'hF0F0, 16'h0FF0, 1'b0, 1'b0, 1'b1, 16'h000F, 1'b0, 1'b0);
      step("sub_zy",      OP_SUB, 16'h8001, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h8001, 1'b0, 1'b1);
      step("or",          OP_OR,  16'hF0F0, 16'h0FF0, 1'b0, 1'b0, 1'b0, 16'hFFF0, 1'b0, 1'b1);

      // Async reset between edges clears outputs immediately.
      #2;
      rst = 1'b1;
      #1;
      check_out("rst_async", 16'h0000, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      check_out("rst_over_edge", 16'h0000, 1'b1, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      // First edge after release loads the current (OR) inputs.
      @(posedge clk);
      #1;
      check_out("post_rst_load", 16'hFFF0, 1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
      $finish;
   end

endmodule
